mips_encoder: RTL
=================

// Module: mips_encoder
// PURPOSE
//  Converse of the Lab6 instruction decoder: packs symbolic instructions (mnemonic id + fields) into
//  32-bit MIPS words and streams them, with target word addresses, to the instruction-memory
//  loader. Sits between the testbench/program source and instruction memory.
//  Covers the decoder's instruction set: add sub and or nor xor addi andi ori xori beq bne j jr lui slt lw lbu sw sb addm.
// PARAMETERS
//  ADDR_W  10  width of word-address counter (out_addr); last address = 2**ADDR_W-1
// PORTS
//  clock      in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-low; clears all state
//  start      in   1   1-cycle pulse: load base_addr, enter RUN
//  base_addr  in   ADDR_W first word address of the program
//  in_valid   in   1   source has an instruction
//  in_ready   out  1   encoder accepts this cycle
//  in_mnem    in   5   mnemonic code MN_* (package)
//  in_rs/in_rt/in_rd in 5 each  register fields
//  in_imm     in   16  immediate / branch offset
//  in_target  in   26  jump target field
//  out_valid  out  1   out_inst/out_addr/out_err valid
//  out_ready  in   1   memory loader consumes
//  out_inst   out  32  encoded word
//  out_addr   out  ADDR_W word address for out_inst
//  out_err    out  1   mnemonic not supported; out_inst = 32'h0
//  done       out  1   high in DONE state
//  err_count  out  8   saturating count of errored words
// BEHAVIOUR
//  Reset values: in_ready=0, out_valid=0, out_inst=0, out_addr=0, out_err=0, done=0, err_count=0; state IDLE.
//  FSM: IDLE -start-> RUN; RUN -last word at addr 2**ADDR_W-1 consumed-> DONE; DONE -start-> RUN.
//   start in any state: reloads address counter with base_addr, discards held output (out_valid=0).
//  Handshake: transfer on valid&ready, both sides. in_ready = (state==RUN) & (~out_valid | out_ready) & ~start.
//  Latency 1: accepted instruction appears registered on out_* next cycle; full throughput 1/cycle.
//  Output held stable while out_valid & ~out_ready.
//  Encoding: R-type {6'h00,rs,rt,rd,5'h0,funct}; jr {6'h00,rs,15'h0,6'h08};
//   I-type {op,rs,rt,imm}; lui {6'h0f,5'h0,rt,imm}; j {6'h02,target}.
//   Opcodes: addi 08 andi 0c ori 0d xori 0e beq 04 bne 05 lw 23 lbu 24 sw 2b sb 28.
//   Functs: add 20 sub 22 and 24 or 25 xor 26 nor 27 slt 2a addm 2c.
//  Address: out_addr = counter at acceptance; counter +1 on each accepted non-error word;
//   errored word: out_err=1, out_inst=0, out_addr=current counter, counter not advanced.
//  Boundary: acceptance at counter 2**ADDR_W-1 -> after its consumption state DONE, no wrap;
//   err_count saturates at 255; reset mid-stream drops the held word.
// CONFIGURATION
//  MIPS_ENC_ADDM_EN defined: MN_ADDM encoded as R-type funct 2c.
//  Undefined: MN_ADDM treated as unsupported (out_err=1, err_count increments).
// STRUCTURE
//  Shared define file (alongside OP_*/OP0_* constants): add MN_* mnemonic codes (MN_ADD=0 .. MN_ADDM=20).
//  Sub-module mips_encode_fields: purely combinational mnemonic+fields -> {inst, err};
//   top holds FSM, address counter, output register, err_count.
// TESTING
//  reset low then start, base=0x010, add rd=3 rs=1 rt=2 -> out_inst=32'h00221820, out_addr=0x010
//  addi rt=8 rs=0 imm=16'hffff then j target=26'h0000040 -> 32'h2008ffff @0x011, 32'h08000040 @0x012
//  out_ready=0 for 3 cycles with 2 pending -> out_* stable, in_ready=0, no loss/duplication
//  in_mnem=31 -> out_err=1, out_inst=0, err_count=1, next valid word reuses same out_addr
//  base=2**ADDR_W-2, send 3 words -> 2 emitted, done=1, in_ready=0; start reloads and resumes
//  addm rd=4 rs=5 rt=6: with MIPS_ENC_ADDM_EN -> 32'h00a6202c; without -> out_err=1

Source files
------------

// File: rtl/mips_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder: mnemonic codes,
// primary opcodes (OP_*), R-type function codes (OP0_*) and word builders.
package mips_encoder_pkg;

    // Mnemonic codes presented on in_mnem
    localparam logic [4:0] MN_ADD  = 5'd0;
    localparam logic [4:0] MN_SUB  = 5'd1;
    localparam logic [4:0] MN_AND  = 5'd2;
    localparam logic [4:0] MN_OR   = 5'd3;
    localparam logic [4:0] MN_NOR  = 5'd4;
    localparam logic [4:0] MN_XOR  = 5'd5;
    localparam logic [4:0] MN_ADDI = 5'd6;
    localparam logic [4:0] MN_ANDI = 5'd7;
    localparam logic [4:0] MN_ORI  = 5'd8;
    localparam logic [4:0] MN_XORI = 5'd9;
    localparam logic [4:0] MN_BEQ  = 5'd10;
    localparam logic [4:0] MN_BNE  = 5'd11;
    localparam logic [4:0] MN_J    = 5'd12;
    localparam logic [4:0] MN_JR   = 5'd13;
    localparam logic [4:0] MN_LUI  = 5'd14;
    localparam logic [4:0] MN_SLT  = 5'd15;
    localparam logic [4:0] MN_LW   = 5'd16;
    localparam logic [4:0] MN_LBU  = 5'd17;
    localparam logic [4:0] MN_SW   = 5'd18;
    localparam logic [4:0] MN_SB   = 5'd19;
    localparam logic [4:0] MN_ADDM = 5'd20;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes
    localparam logic [5:0] OP0_JR   = 6'h08;
    localparam logic [5:0] OP0_ADD  = 6'h20;
    localparam logic [5:0] OP0_SUB  = 6'h22;
    localparam logic [5:0] OP0_AND  = 6'h24;
    localparam logic [5:0] OP0_OR   = 6'h25;
    localparam logic [5:0] OP0_XOR  = 6'h26;
    localparam logic [5:0] OP0_NOR  = 6'h27;
    localparam logic [5:0] OP0_SLT  = 6'h2a;
    localparam logic [5:0] OP0_ADDM = 6'h2c;

    // Three-register ALU word; shamt is always zero here
    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'h00, funct};
    endfunction

    // Immediate / branch / load-store word
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_encode_fields.sv
// Combinational mnemonic + fields -> {32-bit MIPS word, unsupported flag}.
// Build option: MIPS_ENC_ADDM_EN enables encoding of MN_ADDM (funct 2c);
// without it, addm is reported as unsupported.
module mips_encode_fields
    import mips_encoder_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] inst,
    output logic        err
);

    // Select the word layout from the mnemonic; unknown codes yield zero + err
    always_comb begin
        inst = 32'h0000_0000;
        err  = 1'b0;
        case (mnem)
            MN_ADD:  inst = enc_r(rs, rt, rd, OP0_ADD);
            MN_SUB:  inst = enc_r(rs, rt, rd, OP0_SUB);
            MN_AND:  inst = enc_r(rs, rt, rd, OP0_AND);
            MN_OR:   inst = enc_r(rs, rt, rd, OP0_OR);
            MN_NOR:  inst = enc_r(rs, rt, rd, OP0_NOR);
            MN_XOR:  inst = enc_r(rs, rt, rd, OP0_XOR);
            MN_SLT:  inst = enc_r(rs, rt, rd, OP0_SLT);
            MN_ADDI: inst = enc_i(OP_ADDI, rs, rt, imm);
            MN_ANDI: inst = enc_i(OP_ANDI, rs, rt, imm);
            MN_ORI:  inst = enc_i(OP_ORI,  rs, rt, imm);
            MN_XORI: inst = enc_i(OP_XORI, rs, rt, imm);
            MN_BEQ:  inst = enc_i(OP_BEQ,  rs, rt, imm);
            MN_BNE:  inst = enc_i(OP_BNE,  rs, rt, imm);
            MN_LW:   inst = enc_i(OP_LW,   rs, rt, imm);
            MN_LBU:  inst = enc_i(OP_LBU,  rs, rt, imm);
            MN_SW:   inst = enc_i(OP_SW,   rs, rt, imm);
            MN_SB:   inst = enc_i(OP_SB,   rs, rt, imm);
            MN_LUI:  inst = enc_i(OP_LUI,  5'h00, rt, imm);
            MN_J:    inst = {OP_J, target};
            MN_JR:   inst = {OP_RTYPE, rs, 15'h0000, OP0_JR};
`ifdef MIPS_ENC_ADDM_EN
            MN_ADDM: inst = enc_r(rs, rt, rd, OP0_ADDM);
`else
            MN_ADDM: err  = 1'b1;
`endif
            default: err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_encoder.sv
// MIPS instruction encoder: accepts symbolic instructions, emits encoded
// words with consecutive word addresses towards the instruction-memory loader.
// Build option: MIPS_ENC_ADDM_EN (passed through to mips_encode_fields).
module mips_encoder
    import mips_encoder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              done,
    output logic [7:0]        err_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_r;
    logic [ADDR_W-1:0] addr_r;
    logic              full_r;      // last address already handed out; no more accepts
    logic [31:0]       enc_inst_s;
    logic              enc_err_s;
    logic              accept_s;
    logic              consume_s;

    mips_encode_fields u_fields (
        .mnem   (in_mnem),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .imm    (in_imm),
        .target (in_target),
        .inst   (enc_inst_s),
        .err    (enc_err_s)
    );

    // Accept while running, with room in the output register, and address space left
    assign in_ready  = (state_r == ST_RUN) & (~out_valid | out_ready) & ~start & ~full_r;
    assign accept_s  = in_valid & in_ready;
    assign consume_s = out_valid & out_ready;
    assign done      = (state_r == ST_DONE);

    // FSM, address counter and end-of-address-space flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            full_r  <= 1'b0;
        end else if (start) begin
            state_r <= ST_RUN;
            addr_r  <= base_addr;
            full_r  <= 1'b0;
        end else begin
            if (accept_s && !enc_err_s) begin
                if (addr_r == ADDR_LAST) begin
                    full_r <= 1'b1;
                end else begin
                    addr_r <= addr_r + ADDR_ONE;
                end
            end
            // Once full, the held word is the final one; its consumption ends the run
            if ((state_r == ST_RUN) && full_r && consume_s) begin
                state_r <= ST_DONE;
            end
        end
    end

    // Output register: load on accept, drop on consume or start, otherwise hold
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_inst  <= 32'h0000_0000;
            out_addr  <= {ADDR_W{1'b0}};
            out_err   <= 1'b0;
        end else if (start) begin
            out_valid <= 1'b0;
        end else if (accept_s) begin
            out_valid <= 1'b1;
            out_inst  <= enc_inst_s;
            out_addr  <= addr_r;
            out_err   <= enc_err_s;
        end else if (consume_s) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of accepted unsupported mnemonics
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count <= 8'd0;
        end else if (accept_s && enc_err_s && (err_count != 8'hff)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule
